// File: rtl/demux_1x4_deser_pkg.sv
// demux_1x4_deser_pkg
// Shared definitions for the 1-to-4 slot deserializer and the matching
// mux-side serializer on the ALU datapath.
//   SLOT_W       : width of a slot index
//   NSLOT        : number of slots in one frame
//   SLOT0..SLOT3 : slot select encodings; slot k drives/receives outk
//   deser_phase_e: implicit counter phase (IDLE at slot 0, COLLECT otherwise)
//   slot_phase() : maps a slot index to its phase
package demux_1x4_deser_pkg;

  localparam int SLOT_W = 2;
  localparam int NSLOT  = 4;

  localparam logic [SLOT_W-1:0] SLOT0 = 2'b00;
  localparam logic [SLOT_W-1:0] SLOT1 = 2'b01;
  localparam logic [SLOT_W-1:0] SLOT2 = 2'b10;
  localparam logic [SLOT_W-1:0] SLOT3 = 2'b11;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } deser_phase_e;

  // Any slot other than 0 means a frame is partly assembled.
  function automatic deser_phase_e slot_phase(input logic [SLOT_W-1:0] slot);
    return (slot == SLOT0) ? ST_IDLE : ST_COLLECT;
  endfunction

endpackage

// File: rtl/demux_1x4_deser_slot_counter.sv
// demux_slot_counter
// Modulo-4 slot counter that steers serial bits to their output slot.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, counter returns to slot 0
//   inc_i   : advance to the next slot
//   clr_i   : resynchronise; with inc_i the current bit is slot 0 so the
//             counter lands on slot 1, without it the counter lands on slot 0
//   slot_o  : registered slot the next accepted bit will occupy
//   wrap_o  : the current increment completes slot 3 and wraps to slot 0
module demux_slot_counter
  import demux_1x4_deser_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              clr_i,
  output logic [SLOT_W-1:0] slot_o,
  output logic              wrap_o
);

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  // Next slot: a resync beats a plain increment, and a resync that also
  // carries a bit has already consumed slot 0.
  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = inc_i ? SLOT1 : SLOT0;
    end else if (inc_i) begin
      slot_d = slot_q + 2'd1;
    end
  end

  // Slot register.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= SLOT0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;
  assign wrap_o = inc_i & ~clr_i & (slot_q == SLOT3);

endmodule

// File: rtl/demux_1x4_deser.sv
// demux_1x4_deser
// Registered 1-to-4 demultiplexer/deserializer: receives a 4-slot
// time-division bit stream and presents each complete frame in parallel.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset, drops any partial frame
//   in          : serial data bit
//   in_valid    : in is sampled on this edge
//   frame_start : current bit (if valid) is slot 0; discards a partial frame
//   out0..out3  : last completed frame, slot k on outk
//   sel0, sel1  : slot the next accepted bit will occupy, {sel1,sel0}
//   frame_valid : one-cycle pulse, a new frame was just written to outk
//   sync_err    : one-cycle pulse, a partial frame was discarded
module demux_1x4_deser
  import demux_1x4_deser_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in,
  input  logic in_valid,
  input  logic frame_start,
  output logic out0,
  output logic out1,
  output logic out2,
  output logic out3,
  output logic sel0,
  output logic sel1,
  output logic frame_valid,
  output logic sync_err
);

  logic [SLOT_W-1:0] slot;
  logic              wrap;
  logic              partial;

  logic [2:0] shadow_q, shadow_d;
  logic [3:0] out_q, out_d;
  logic       frame_valid_q, frame_valid_d;
  logic       sync_err_q, sync_err_d;

  demux_slot_counter u_slot_counter (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (in_valid),
    .clr_i  (frame_start),
    .slot_o (slot),
    .wrap_o (wrap)
  );

  assign partial = (slot_phase(slot) == ST_COLLECT);

  // Shadow collects slots 0-2; the outputs only load on the bit that fills
  // slot 3, so a partial frame never reaches out0..out3. The two strobes
  // come from mutually exclusive branches and can never coincide.
  always_comb begin
    shadow_d      = shadow_q;
    out_d         = out_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (frame_start) begin
      shadow_d   = 3'b000;
      sync_err_d = partial;
      if (in_valid) begin
        shadow_d[0] = in;
      end
    end else if (in_valid) begin
      if (wrap) begin
        out_d         = {in, shadow_q};
        shadow_d      = 3'b000;
        frame_valid_d = 1'b1;
      end else begin
        case (slot)
          SLOT0:   shadow_d[0] = in;
          SLOT1:   shadow_d[1] = in;
          default: shadow_d[2] = in;
        endcase
      end
    end
  end

  // Data and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q      <= 3'b000;
      out_q         <= 4'b0000;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      out_q         <= out_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign out0        = out_q[0];
  assign out1        = out_q[1];
  assign out2        = out_q[2];
  assign out3        = out_q[3];
  assign sel0        = slot[0];
  assign sel1        = slot[1];
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_demux_1x4_deser.sv
// tb_demux_1x4_deser
// Directed bench for demux_1x4_deser. Expected values are packed as
// {out0,out1,out2,out3, sel1,sel0, frame_valid, sync_err}.
module tb_demux_1x4_deser;

  logic clk;
  logic rst;
  logic serialIn;
  logic inValid;
  logic frameStart;
  logic out0, out1, out2, out3;
  logic sel0, sel1;
  logic frameValid;
  logic syncErr;

  int errors = 0;
  int checks = 0;

  demux_1x4_deser dut (
    .clk         (clk),
    .rst         (rst),
    .in          (serialIn),
    .in_valid    (inValid),
    .frame_start (frameStart),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .sel0        (sel0),
    .sel1        (sel1),
    .frame_valid (frameValid),
    .sync_err    (syncErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then let outputs settle just after the edge.
  task automatic applyStimulus(input logic r, input logic b, input logic v, input logic fs);
    rst        = r;
    serialIn   = b;
    inValid    = v;
    frameStart = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expected);
    logic [7:0] observed;
    observed = {out0, out1, out2, out3, sel1, sel0, frameValid, syncErr};
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; serialIn = 1'b0; inValid = 1'b0; frameStart = 1'b0;

    // Reset state.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("reset", 8'b0000_00_0_0);

    // Basic frame 1010 with frame_start on the first bit.
    applyStimulus(0, 1, 1, 1); checkOutput("t1_b0", 8'b0000_01_0_0);
    applyStimulus(0, 0, 1, 0); checkOutput("t1_b1", 8'b0000_10_0_0);
    applyStimulus(0, 1, 1, 0); checkOutput("t1_b2", 8'b0000_11_0_0);
    applyStimulus(0, 0, 1, 0); checkOutput("t1_b3", 8'b1010_00_1_0);
    applyStimulus(0, 0, 0, 0); checkOutput("t1_idle", 8'b1010_00_0_0);

    // Same bits with gaps 0, 3, 1 between them.
    applyStimulus(1, 0, 0, 0); checkOutput("t2_reset", 8'b0000_00_0_0);
    applyStimulus(0, 1, 1, 0); checkOutput("t2_b0", 8'b0000_01_0_0);
    applyStimulus(0, 0, 1, 0); checkOutput("t2_b1", 8'b0000_10_0_0);
    applyStimulus(0, 1, 0, 0); checkOutput("t2_gap_a", 8'b0000_10_0_0);
    applyStimulus(0, 0, 0, 0); checkOutput("t2_gap_b", 8'b0000_10_0_0);
    applyStimulus(0, 1, 0, 1'b0); checkOutput("t2_gap_c", 8'b0000_10_0_0);
    applyStimulus(0, 1, 1, 0); checkOutput("t2_b2", 8'b0000_11_0_0);
    applyStimulus(0, 0, 0, 0); checkOutput("t2_gap_d", 8'b0000_11_0_0);
    applyStimulus(0, 0, 1, 0); checkOutput("t2_b3", 8'b1010_00_1_0);
    applyStimulus(0, 0, 0, 0); checkOutput("t2_idle", 8'b1010_00_0_0);

    // Back-to-back frames 1010 then 0110.
    applyStimulus(0, 1, 1, 0); checkOutput("t3_f1_b0", 8'b1010_01_0_0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 1, 0); checkOutput("t3_f1_done", 8'b1010_00_1_0);
    applyStimulus(0, 0, 1, 0); checkOutput("t3_f2_b0", 8'b1010_01_0_0);
    applyStimulus(0, 1, 1, 0); checkOutput("t3_f2_b1", 8'b1010_10_0_0);
    applyStimulus(0, 1, 1, 0); checkOutput("t3_f2_b2", 8'b1010_11_0_0);
    applyStimulus(0, 0, 1, 0); checkOutput("t3_f2_done", 8'b0110_00_1_0);
    applyStimulus(0, 0, 0, 0); checkOutput("t3_idle", 8'b0110_00_0_0);

    // Resync after two bits, carrying a new slot-0 bit.
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0); checkOutput("t4_partial", 8'b0110_10_0_0);
    applyStimulus(0, 0, 1, 1); checkOutput("t4_resync", 8'b0110_01_0_1);
    applyStimulus(0, 1, 1, 0); checkOutput("t4_b1", 8'b0110_10_0_0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0); checkOutput("t4_done", 8'b0111_00_1_0);

    // Reset mid-frame drops the partial frame silently.
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0); checkOutput("t5_partial", 8'b0111_11_0_0);
    applyStimulus(1, 1, 1, 0); checkOutput("t5_reset", 8'b0000_00_0_0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0); checkOutput("t5_done", 8'b0001_00_1_0);

    // frame_start without data at slot 0 is silent.
    applyStimulus(0, 1, 0, 1); checkOutput("t6_fs_idle", 8'b0001_00_0_0);

    // frame_start without data mid-frame clears to slot 0 with sync_err.
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 1); checkOutput("t7_fs_clear", 8'b0001_00_0_1);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0); checkOutput("t7_done", 8'b1100_00_1_0);

    // frame_start on what would be the 4th bit aborts the frame.
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 1); checkOutput("t8_abort", 8'b1100_01_0_1);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0); checkOutput("t8_done", 8'b1000_00_1_0);
    applyStimulus(0, 0, 0, 0); checkOutput("t8_idle", 8'b1000_00_0_0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1x4_deser.md
# demux_1x4_deser

Registered 1-to-4 demultiplexer/deserializer: the receiving end of a 4-slot time-division bit stream. Each accepted serial bit is steered to one of four output slots by an internal 2-bit slot counter. A complete 4-bit frame is presented on `out0`..`out3` with a one-cycle `frame_valid` strobe. It reassembles the `c0`..`c3` operand bits that a select-driven 4x1 mux stage serializes on the ALU datapath.

## Interface
- `NSLOT`, 4: number of slots; fixed at 4, slot index is 2 bits.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in`  in  1  serial data bit.
- `in_valid`  in  1  `in` is sampled on this edge when high.
- `frame_start`  in  1  resynchronise: current bit, if valid, is slot 0.
- `out0`, `out1`, `out2`, `out3`  out  1 each  last completed frame; slot k lands on `outk`.
- `sel0`, `sel1`  out  1 each  current slot index, `{sel1,sel0}`; `sel0` is the LSB.
- `frame_valid`  out  1  one-cycle pulse: a new frame was just written to `out0`..`out3`.
- `sync_err`  out  1  one-cycle pulse: a partial frame was discarded by `frame_start`.

## Operation
- Slot mapping matches the mux select encoding:
  - `{sel1,sel0}` = 00 → `out0`
  - 01 → `out1`
  - 10 → `out2`
  - 11 → `out3`
- Internal state: 2-bit slot counter, 3-bit shadow register for slots 0–2, and a `partial` flag (set when slot ≠ 0).
- The counter has two implicit states: IDLE (slot 0, shadow empty) and COLLECT (slot 1–3).
- Accept (`in_valid`=1, `frame_start`=0):
  - Slots 0–2: `in` is written to `shadow[slot]` and the slot increments.
  - Slot 3: `out0..out2` ← `shadow`, `out3` ← `in`, the slot wraps to 0, and `frame_valid` is set.
- `frame_start`=1 with `in_valid`=1:
  - The shadow is discarded and `in` is written to `shadow[0]`; slot becomes 1.
  - `sync_err` pulses if the slot was ≠ 0 beforehand.
- `frame_start`=1 with `in_valid`=0:
  - Slot becomes 0 and the shadow is cleared.
  - `sync_err` pulses if the slot was ≠ 0.
  - Outputs are unchanged.
- `in_valid`=0 and `frame_start`=0: all state holds. Gaps of any length between bits are legal.
- `out0`..`out3` only change on frame completion, so a partial frame is never visible.

## Timing
- Reset: `out0..out3`=0, `sel0`=`sel1`=0, `frame_valid`=0, `sync_err`=0, shadow=0. Reset takes priority over all inputs; a partial frame in progress is dropped with no `sync_err`.
- Latency: `out0..out3` update on the edge that samples the 4th bit. `frame_valid` is high for exactly the following cycle, aligned with the new outputs.
- Back-to-back frames (`in_valid` held high) give a `frame_valid` pulse every 4 cycles with no bubble.
- `sel0`/`sel1` are registered. They show the slot the next accepted bit will occupy.
- `frame_start` at slot 0 is silent: no `sync_err`, and the bit is accepted normally.
- `frame_start` on what would be the 4th bit: the frame is not completed, `frame_valid` stays 0, and `sync_err`=1.
- `sync_err` and `frame_valid` are never high in the same cycle.

## Structure
- Shared package holds:
  - `SLOT_W` = 2
  - `NSLOT` = 4
  - slot constants `SLOT0`..`SLOT3` (00, 01, 10, 11), also used by the mux-side serializer.
- One sub-module, `demux_slot_counter`:
  - 2-bit modulo-4 counter with `inc`, `clr` and a wrap output.
  - Drives `sel0`/`sel1`.
- Top level holds the shadow register, output registers and strobe logic.

## Test plan
- Reset, then in=1,0,1,0 with `in_valid`=1 on 4 consecutive cycles, `frame_start`=1 on the first → `out0..3`=1,0,1,0; `frame_valid`=1 for one cycle; `{sel1,sel0}` steps 01,10,11,00.
- Same bits with `in_valid` gaps of 0, 3, 1 cycles between bits → identical outputs. `frame_valid` is asserted only after the 4th bit. `out0..3` stay 0 until then.
- Two back-to-back frames 1010 then 0110 with `in_valid` held high → `frame_valid` pulses 4 cycles apart. Second result is `out0..3`=0,1,1,0.
- After 2 bits (1,1), `frame_start` with in=0 → `sync_err` pulse; slot=1; previous outputs held. Then 3 more bits 1,1,1 → outputs 0,1,1,1.
- `rst` asserted after 3 bits of frame 1111 → all outputs 0 next cycle, no `frame_valid`, no `sync_err`. A following full frame 0001 completes correctly.
- `frame_start`=1 with `in_valid`=0 at slot 0 → no `sync_err`, no state change.
